// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and whole-pipe
// freezes on data-memory stalls, with saturating stall/flush performance counters.
module pipeline_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rt_i,
    input  logic        branch_taken_i,
    input  logic        mem_stall_i,
    input  logic        clr_cnt_i,
    output logic        pc_write_o,
    output logic        if_id_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic        freeze_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FREEZE = 2'b01,
        REPLAY = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        lu;

    assign lu = ex_memread_i && (ex_rt_i != '0) &&
                ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

    always_comb begin
        state_d        = RUN;
        pend_d         = pend_q;
        pc_write_o     = 1'b1;
        if_id_hold_o   = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        freeze_o       = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall_i) begin
                    freeze_o     = 1'b1;
                    if_id_hold_o = 1'b1;
                    pc_write_o   = 1'b0;
                    state_d      = FREEZE;
                end else if (lu) begin
                    // A branch resolved alongside a load-use is re-evaluated next cycle.
                    pc_write_o     = 1'b0;
                    if_id_hold_o   = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end else begin
                    if_id_flush_o = branch_taken_i;
                end
            end
            FREEZE: begin
                freeze_o     = 1'b1;
                if_id_hold_o = 1'b1;
                pc_write_o   = 1'b0;
                pend_d       = pend_q | branch_taken_i;
                if (mem_stall_i) state_d = FREEZE;
                else             state_d = pend_d ? REPLAY : RUN;
            end
            REPLAY: begin
                if (mem_stall_i) begin
                    freeze_o     = 1'b1;
                    if_id_hold_o = 1'b1;
                    pc_write_o   = 1'b0;
                    state_d      = FREEZE;
                end else begin
                    if_id_flush_o = 1'b1;
                    pend_d        = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst_i) begin
            pc_write_o     = 1'b0;
            if_id_hold_o   = 1'b1;
            if_id_flush_o  = 1'b0;
            id_ex_bubble_o = 1'b0;
            freeze_o       = 1'b0;
        end

        if (clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
            if (!pc_write_o && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 16'd1;
            if (if_id_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes model expectations,
// a negedge monitor pops and compares against the DUT.
module tb_pipeline_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
    logic        ex_memread_i, branch_taken_i, mem_stall_i, clr_cnt_i;
    logic        pc_write_o, if_id_hold_o, if_id_flush_o, id_ex_bubble_o, freeze_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    pipeline_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rt_i        (ex_rt_i),
        .branch_taken_i (branch_taken_i),
        .mem_stall_i    (mem_stall_i),
        .clr_cnt_i      (clr_cnt_i),
        .pc_write_o     (pc_write_o),
        .if_id_hold_o   (if_id_hold_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .freeze_o       (freeze_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        pcw, hold, flush, bubble, frz;
        logic [1:0]  st;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_cyc    = 0;

    // Reference model: mode 0=run, 1=frozen, 2=replaying a deferred flush.
    int m_mode = 0;
    bit m_pend = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    function automatic exp_t model_out();
        exp_t e;
        bit   lu;
        lu = ex_memread_i && (ex_rt_i != 0) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
        e.pcw = 1; e.hold = 0; e.flush = 0; e.bubble = 0; e.frz = 0;
        e.st = 2'(m_mode);
        e.sc = 16'(m_sc);
        e.fc = 16'(m_fc);
        if (!rst_i) begin
            e.pcw = 0; e.hold = 1;
        end else if (mem_stall_i || m_mode == 1) begin
            e.pcw = 0; e.hold = 1; e.frz = 1;
        end else if (m_mode == 2) begin
            e.flush = 1;
        end else if (lu) begin
            e.pcw = 0; e.hold = 1; e.bubble = 1;
        end else begin
            e.flush = branch_taken_i;
        end
        return e;
    endfunction

    task automatic model_step();
        exp_t e;
        e = model_out();
        if (clr_cnt_i) begin
            m_sc = 0; m_fc = 0;
        end else begin
            if (!e.pcw)  m_sc = (m_sc >= 65535) ? 65535 : m_sc + 1;
            if (e.flush) m_fc = (m_fc >= 65535) ? 65535 : m_fc + 1;
        end
        if (m_mode == 1) begin
            if (branch_taken_i) m_pend = 1;
            if (!mem_stall_i) m_mode = m_pend ? 2 : 0;
        end else if (mem_stall_i) begin
            m_mode = 1;
        end else begin
            if (m_mode == 2) m_pend = 0;
            m_mode = 0;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, n_cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            n_cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_write",  16'(pc_write_o),     16'(e.pcw));
                check("if_id_hold", 16'(if_id_hold_o),  16'(e.hold));
                check("if_id_flush", 16'(if_id_flush_o), 16'(e.flush));
                check("id_ex_bubble", 16'(id_ex_bubble_o), 16'(e.bubble));
                check("freeze",    16'(freeze_o),       16'(e.frz));
                check("state",     16'(state_o),        16'(e.st));
                check("stall_cnt", stall_cnt_o,         e.sc);
                check("flush_cnt", flush_cnt_o,         e.fc);
            end
        end
    end

    task automatic cyc(input logic ms, input logic rd, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic clr);
        mem_stall_i = ms; ex_memread_i = rd; ex_rt_i = ert;
        id_rs_i = rs; id_rt_i = rt; branch_taken_i = br; clr_cnt_i = clr;
        sb.push_back(model_out());
        @(posedge clk_i);
        if (rst_i) model_step();
        #1;
    endtask

    // Asserts reset between edges, checks the immediate response, then releases.
    task automatic async_reset();
        #1;
        rst_i = 1'b0;
        model_reset();
        sb.push_back(model_out());
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin : stim
        rst_i = 1'b0;
        {mem_stall_i, ex_memread_i, branch_taken_i, clr_cnt_i} = '0;
        ex_rt_i = '0; id_rs_i = '0; id_rt_i = '0;
        @(posedge clk_i); #1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 5, 5, 1, 0);
        rst_i = 1'b1;

        cyc(0, 1, 5, 5, 9, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 0, 0);
        cyc(0, 1, 7, 1, 7, 1, 0);
        cyc(0, 0, 7, 1, 7, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        async_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cyc(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 31) == 0));
            end
        end

        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) cyc(0, 1, 4, 4, 0, 0, 0);
        cyc(0, 1, 4, 4, 0, 0, 1);
        cyc(0, 1, 4, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
